// File: rtl/uart_rx_if.sv
// uart_rx output bundle: received byte, strobes, held temperature, busy.
// master drives (receiver), slave observes (downstream logic).
interface uart_rx_if;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic [6:0] temp;
  logic       busy;

  modport master (
    output data,
    output data_valid,
    output frame_err,
    output temp,
    output busy
  );

  modport slave (
    input data,
    input data_valid,
    input frame_err,
    input temp,
    input busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop sync, mid-bit sampling, start/stop check.
// Ports: clk, nRST (async low), uart_rx_line, o_rx (uart_rx_if.master).
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic clk,
  input  logic nRST,
  input  logic uart_rx_line,
  uart_rx_if.master o_rx
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CLOG = $clog2(CLKS_PER_BIT);
  localparam int CW = (CLOG > 9) ? CLOG : 9;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID = CW'(HALF);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_IDLE
  } state_t;

  logic          r_s1;
  logic          r_s2;
  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_sh;
  logic [7:0]    r_data;
  logic          r_dv;
  logic          r_fe;
  logic [6:0]    r_temp;
  logic          w_busy;
  logic          w_tick;
  logic          w_half;

  assign w_tick = (r_cnt == LAST);
  assign w_half = (r_cnt == MID);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= uart_rx_line;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (!r_s2) w_next = START;
      START:     if (w_half) w_next = r_s2 ? IDLE : DATA;
      DATA:      if (w_tick && r_idx == 3'd7) w_next = STOP;
      STOP:      if (w_tick) w_next = r_s2 ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (r_s2) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_sh   <= '0;
      r_data <= '0;
      r_dv   <= 1'b0;
      r_fe   <= 1'b0;
      r_temp <= '0;
    end else begin
      r_dv <= 1'b0;
      r_fe <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
        end
        START: begin
          r_idx <= '0;
          r_cnt <= w_half ? '0 : r_cnt + 1'b1;
        end
        DATA: begin
          if (w_tick) begin
            r_cnt       <= '0;
            r_sh[r_idx] <= r_s2;
            r_idx       <= r_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (w_tick) begin
            r_cnt <= '0;
            if (r_s2) begin
              r_data <= r_sh;
              r_dv   <= 1'b1;
              // bit 7 set marks a non-temperature byte
              if (!r_sh[7]) r_temp <= r_sh[6:0];
            end else begin
              r_fe <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  always_comb begin
    w_busy = (r_state != IDLE);
  end

  assign o_rx.data       = r_data;
  assign o_rx.data_valid = r_dv;
  assign o_rx.frame_err  = r_fe;
  assign o_rx.temp       = r_temp;
  assign o_rx.busy       = w_busy;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames, expected pulses queued.
// Monitor pops on each data_valid/frame_err and checks value and cycle.
module tb_uart_rx;
  localparam int CPB  = 434;
  localparam int HALF = 216;
  localparam int LAT  = 3 + HALF + 9 * CPB;

  logic clk  = 1'b0;
  logic nRST = 1'b0;
  logic line = 1'b1;

  uart_rx_if rx_if ();

  uart_rx #(
    .CLK_FREQ(50_000_000),
    .BAUD(115200)
  ) dut (
    .clk(clk),
    .nRST(nRST),
    .uart_rx_line(line),
    .o_rx(rx_if)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         ferr;
    logic [7:0] d;
    logic [6:0] t;
    int         at;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int n_dv = 0;
  int n_fe = 0;
  int last_dv_at = 0;
  int prev_dv_at = 0;
  logic [7:0] m_data = '0;
  logic [6:0] m_temp = '0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (nRST) begin
      if (rx_if.data_valid && rx_if.frame_err)
        chk("dv_fe_overlap", 1, 0);
      if (rx_if.data_valid || rx_if.frame_err) begin
        if (rx_if.data_valid) begin
          n_dv++;
          prev_dv_at = last_dv_at;
          last_dv_at = cyc;
        end else begin
          n_fe++;
        end
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pulse_kind_fe", int'(rx_if.frame_err), int'(e.ferr));
          checks++;
          if (cyc < e.at - 1 || cyc > e.at + 1) begin
            errors++;
            $display("FAIL pulse_cycle: got %0d expected %0d", cyc, e.at);
          end
          chk("pulse_data", rx_if.data, e.d);
          chk("pulse_temp", rx_if.temp, e.t);
        end
      end
    end
  end

  task automatic drive(logic v);
    line = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(int n);
    line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(logic [7:0] b, logic stopv = 1'b1);
    exp_t e;
    if (stopv) begin
      m_data = b;
      if (!b[7]) m_temp = b[6:0];
    end
    e.ferr = !stopv;
    e.d    = m_data;
    e.t    = m_temp;
    e.at   = cyc + 1 + LAT;
    sb.push_back(e);
    drive(1'b0);
    for (int i = 0; i < 8; i++) drive(b[i]);
    drive(stopv);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_data"}, rx_if.data, 0);
    chk({tag, "_dv"}, int'(rx_if.data_valid), 0);
    chk({tag, "_fe"}, int'(rx_if.frame_err), 0);
    chk({tag, "_temp"}, rx_if.temp, 0);
    chk({tag, "_busy"}, int'(rx_if.busy), 0);
  endtask

  initial begin
    int hi;
    int dv_snap;
    logic [7:0] rb;

    repeat (5) @(negedge clk);
    chk_reset_vals("reset");
    nRST = 1'b1;
    idle(10);

    send(8'h48);
    idle(20);
    chk("temp_after_48", rx_if.temp, 72);

    send(8'hC8);
    idle(20);
    chk("data_after_c8", rx_if.data, 8'hC8);
    chk("temp_after_c8", rx_if.temp, 72);
    chk("dv_count_2", n_dv, 2);

    hi = 0;
    line = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i == 100) line = 1'b1;
      @(negedge clk);
      if (rx_if.busy) hi++;
    end
    chk("false_start_busy", hi, HALF + 1);
    chk("false_start_dv", n_dv, 2);
    chk("false_start_fe", n_fe, 0);
    idle(20);
    send(8'h55);
    idle(20);

    send(8'hA5, 1'b0);
    line = 1'b0;
    repeat (1000) @(negedge clk);
    chk("break_busy_a", int'(rx_if.busy), 1);
    repeat (1000) @(negedge clk);
    chk("break_busy_b", int'(rx_if.busy), 1);
    chk("fe_count", n_fe, 1);
    chk("data_held_fe", rx_if.data, 8'h55);
    line = 1'b1;
    repeat (3) @(negedge clk);
    chk("break_release_busy", int'(rx_if.busy), 0);
    idle(20);
    send(8'h3C);
    idle(20);

    send(8'h00);
    send(8'hFF);
    idle(20);
    chk("b2b_spacing", last_dv_at - prev_dv_at, 10 * CPB);
    chk("b2b_last_data", rx_if.data, 8'hFF);

    dv_snap = n_dv;
    rb = 8'h99;
    drive(1'b0);
    for (int i = 0; i < 4; i++) drive(rb[i]);
    line = rb[4];
    repeat (200) @(negedge clk);
    nRST = 1'b0;
    #1;
    chk_reset_vals("midframe_rst");
    m_data = '0;
    m_temp = '0;
    repeat (5) @(negedge clk);
    line = 1'b1;
    nRST = 1'b1;
    repeat (3000) @(negedge clk);
    chk("no_pulse_after_rst", n_dv, dv_snap);
    chk("idle_after_rst", int'(rx_if.busy), 0);

    send(8'h48);
    idle(20);
    chk("loopback_temp", rx_if.temp, 72);

    idle(10);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver that pairs with `uart_tx` on the board's UART link. It recovers 8N1 frames from `uart_rx_line` using mid-bit sampling, and validates the start and stop bits. Each good byte is delivered as a one-cycle strobe. The latest 7-bit temperature value is kept on a held register for downstream logic. It sits at the pin side of the design, in the same 50 MHz `clk` domain as `uart_tx`.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz.
- `BAUD`, 115200, line rate in bit/s. Must equal the `uart_tx` setting.
- Derived (localparam): `CLKS_PER_BIT = CLK_FREQ / BAUD`, integer division, 434 at defaults.
- Derived (localparam): `HALF = (CLKS_PER_BIT - 1) / 2`, 216 at defaults.

Ports (clock and reset first):
- `clk`  input  1  system clock, rising-edge.
- `nRST`  input  1  reset, asynchronous, active-low.
- `uart_rx_line`  input  1  serial input; asynchronous; idle high.
- `data`  output  8  last good byte, held until the next good frame.
- `data_valid`  output  1  one-cycle pulse when `data` is updated.
- `frame_err`  output  1  one-cycle pulse on a bad stop bit.
- `temp`  output  7  last good byte's `[6:0]`; updated only if bit 7 == 0.
- `busy`  output  1  high whenever the FSM is not in IDLE.

## Operation
- **Input synchronizer.** Two flops, `s1` then `s2`, both reset to 1. All logic uses `s2` only.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_IDLE.
- **Counters.** Bit-timer `cnt` is 9 bits minimum; it must cover `CLKS_PER_BIT - 1`. Bit index `idx` is 3 bits. Shift register `sh` is 8 bits.
- **IDLE.** When `s2 == 0`: go to START with `cnt = 0`.
- **START.** `cnt` increments each cycle until `cnt == HALF`, then sample `s2`.
  - `s2 == 0`: go to DATA with `cnt = 0`, `idx = 0`.
  - `s2 == 1`: false start; return to IDLE with no output activity.
- **DATA.** At `cnt == CLKS_PER_BIT - 1`, sample `s2` into `sh[idx]` (LSB first) and reset `cnt` to 0.
  - After `idx == 7`, go to STOP.
- **STOP.** At `cnt == CLKS_PER_BIT - 1`, sample `s2`.
  - `s2 == 1`: `data <= sh`, `data_valid <= 1`. If `sh[7] == 0`, also `temp <= sh[6:0]`. Go to IDLE.
  - `s2 == 0`: `frame_err <= 1`; `data` and `temp` unchanged. Go to WAIT_IDLE.
- **WAIT_IDLE.** Stay until `s2 == 1`, then go to IDLE. This covers break and stuck-low lines: the block never re-triggers on a held-low line.
- **Outputs.** `data_valid` and `frame_err` are registered and self-clear the following cycle. They are never high simultaneously.
- **Reset.** Asserting `nRST` mid-frame aborts immediately. Every register returns to its reset value, and the partial byte is discarded.

## Timing
- **Reset values:** `data = 0`, `data_valid = 0`, `frame_err = 0`, `temp = 0`, `busy = 0`, state = IDLE, `s1 = s2 = 1`.
- **Edge numbering.** Let edge `k` be the first `clk` edge at which `uart_rx_line` is low. Then:
  - `s2` is low after edge `k+1`.
  - START is entered at edge `k+2`.
  - The start sample is taken at edge `k+3+HALF`.
- **Sample points.**
  - Data bit `i` is sampled at edge `k+3+HALF+(i+1)*CLKS_PER_BIT`.
  - The stop bit is sampled at edge `k+3+HALF+9*CLKS_PER_BIT`. At defaults this is `k+4125`.
- **Strobe timing.** `data_valid` or `frame_err` is high for exactly the one cycle following the stop-sample edge. `data` and `temp` change on that same edge.
- **Back-to-back frames.** Returning to IDLE at mid-stop-bit lets a start bit that immediately follows the stop bit be caught, with at most 1 clock of sampling skew.
- **`busy`.** Rises at edge `k+2`. Falls on the edge that enters IDLE.
- **Baud tolerance.** Mid-bit sampling tolerates ±2% baud mismatch at defaults.

## Test plan
- **Good frame.** Drive frame 0x48 at 434 clk/bit → one `data_valid` pulse at edge `k+4125 (±1)`, `data = 0x48`, `temp = 72`, `frame_err` never high.
- **Bit 7 set.** Send 0x48, then 0xC8 → after the second frame `data = 0xC8`, `temp` still 72, two `data_valid` pulses total.
- **False start.** Drive the line low for 100 clocks, then high → no `data_valid`/`frame_err`; `busy` high about 218 clocks, then IDLE; a following 0x55 frame is received correctly.
- **Framing error.** Send 0xA5 with stop bit 0 and hold the line low for 2000 clocks → one `frame_err` pulse, `data` unchanged from its prior value, `busy` stays high until the line returns high, then a 0x3C frame gives `data = 0x3C`.
- **Back-to-back.** Send 0x00 then 0xFF with no idle gap → two `data_valid` pulses exactly 10*434 clocks apart, values 0x00 then 0xFF.
- **Reset and loopback.** Assert `nRST` during data bit 4 of a frame → all outputs are at reset values immediately, with no pulse afterward. Then loop `uart_tx` with `temp = 72` into `uart_rx_line` → `temp` output = 72.
